// File: rtl/ddr_tx_sequencer.sv
// Word FIFO plus pair serializer feeding a DDR output flop: two bits per clock,
// MSB first, gapless between words, idle pattern and underrun flag when dry.
module ddr_tx_sequencer #(
    parameter int         WIDTH     = 8,
    parameter int         DEPTH     = 4,
    parameter logic [1:0] IDLE_PAIR = 2'b00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       d0,
    output logic                       d1,
    output logic                       busy,
    output logic                       word_start,
    output logic                       underrun,
    output logic [$clog2(DEPTH+1)-1:0] fill
);

    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = $clog2(PAIRS);
    localparam int SW    = WIDTH - 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WIDTH-1:0]  head;
    logic              push, pop, push_q, avail, last;
    logic [SW-1:0]     shifter, shift_nxt;
    logic [CW-1:0]     pair_cnt, cnt_nxt;
    logic [1:0]        pair_nxt;
    logic              ws_nxt, ur_nxt;

    assign s_ready = !rst && (fill != FW'(DEPTH));
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];
    // The word written on the previous edge is still in the write path, so
    // only older entries count as available to the serializer.
    assign avail   = fill > FW'(push_q);
    assign last    = (pair_cnt == '0);
    assign busy    = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (en && avail) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    if (en && avail) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pair_nxt  = IDLE_PAIR;
        shift_nxt = shifter;
        cnt_nxt   = pair_cnt;
        ws_nxt    = 1'b0;
        ur_nxt    = 1'b0;
        if (pop) begin
            pair_nxt  = head[WIDTH-1 -: 2];
            shift_nxt = head[SW-1:0];
            cnt_nxt   = CW'(PAIRS - 1);
            ws_nxt    = 1'b1;
        end else if (state == RUN && !last) begin
            pair_nxt  = shifter[SW-1 -: 2];
            shift_nxt = shifter << 2;
            cnt_nxt   = pair_cnt - CW'(1);
        end else if (state == RUN) begin
            // Stream ends here; only an enabled stream that ran dry is an underrun.
            ur_nxt = en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {d0, d1}   <= IDLE_PAIR;
            shifter    <= '0;
            pair_cnt   <= '0;
            word_start <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            {d0, d1}   <= pair_nxt;
            shifter    <= shift_nxt;
            pair_cnt   <= cnt_nxt;
            word_start <= ws_nxt;
            underrun   <= ur_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= push;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Bench for ddr_tx_sequencer: queue-based reference model checked every cycle,
// directed literal scenarios, then randomized traffic with enable/reset churn.
module tb_ddr_tx_sequencer;
    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 4;
    localparam int         PAIRS     = WIDTH / 2;
    localparam logic [1:0] IDLE_PAIR = 2'b00;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_ready, d0, d1, busy, word_start, underrun;
    logic [2:0]       fill;

    ddr_tx_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_PAIR(IDLE_PAIR)) dut (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .d0(d0), .d1(d1), .busy(busy),
        .word_start(word_start), .underrun(underrun), .fill(fill)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO as a queue tagged with the edge number of each push.
    // A word may be taken only from the second edge after it was written.
    logic [WIDTH-1:0] mq[$];
    int               mt[$];
    int               edge_n = 0;
    bit               m_ok = 0;
    bit               m_run = 0;
    logic [WIDTH-1:0] m_word = '0;
    int               m_idx = 0;
    bit               m_ws = 0, m_ur = 0;

    function automatic int exp_pair();
        if (m_run) return int'((m_word >> (WIDTH - 2 - 2 * m_idx)) & 8'h03);
        return int'(IDLE_PAIR);
    endfunction

    always @(posedge clk) begin : model
        bit sr, pu;
        sr = !rst && (mq.size() != DEPTH);
        pu = s_valid && sr;
        if (rst) begin
            mq.delete();
            mt.delete();
            m_run = 0; m_ws = 0; m_ur = 0; m_ok = 1;
        end else begin
            m_ws = 0; m_ur = 0;
            if (m_run && m_idx < PAIRS - 1) begin
                m_idx++;
            end else if (en && mq.size() > 0 && mt[0] < edge_n - 1) begin
                m_word = mq.pop_front();
                void'(mt.pop_front());
                m_idx = 0; m_run = 1; m_ws = 1;
            end else begin
                m_ur  = m_run && en;
                m_run = 0;
            end
            if (pu) begin
                mq.push_back(s_data);
                mt.push_back(edge_n);
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_pair", {d0, d1}, exp_pair());
            chk("m_busy", busy, m_run);
            chk("m_word_start", word_start, m_ws);
            chk("m_underrun", underrun, m_ur);
            chk("m_fill", fill, mq.size());
            chk("m_s_ready", s_ready, (!rst && mq.size() != DEPTH));
            chk("m_pulse_excl", word_start && underrun, 0);
        end
    end

    int single_pairs[4] = '{2, 3, 1, 0};
    int b2b_pairs[16]   = '{2, 3, 1, 0, 1, 1, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0};

    initial begin
        // Reset held with a valid word presented
        s_valid = 1'b1; s_data = 8'hA5;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_pair", {d0, d1}, 0);
        chk("rst_fill", fill, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1);

        // Single word 0xB4 with en high
        tick();
        en = 1'b1; s_valid = 1'b1; s_data = 8'hB4;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("single_pair", {d0, d1}, (k >= 2 && k <= 5) ? single_pairs[k-2] : 0);
            chk("single_ws", word_start, (k == 2));
            chk("single_ur", underrun, (k == 6));
            chk("single_busy", busy, (k >= 2 && k <= 5));
        end

        // Back-to-back: fill the FIFO with en low, fifth word held off
        tick();
        en = 1'b0; s_valid = 1'b1; s_data = 8'hB4;
        tick(); s_data = 8'h5A;
        tick(); s_data = 8'hFF;
        tick(); s_data = 8'h00;
        tick(); s_data = 8'h77;
        @(negedge clk);
        chk("full_s_ready", s_ready, 0);
        chk("full_fill", fill, 4);
        tick();
        @(negedge clk);
        chk("full_held", s_ready, 0);
        tick();
        s_valid = 1'b0; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_pair", {d0, d1}, b2b_pairs[i]);
            chk("b2b_ws", word_start, (i % 4 == 0));
            chk("b2b_ur", underrun, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("b2b_end_ur", underrun, 1);
        chk("b2b_end_fill", fill, 0);

        // en dropped during the second pair of the first of two words
        tick();
        en = 1'b0; s_valid = 1'b1; s_data = 8'hC3;
        tick(); s_data = 8'h96;
        tick(); s_valid = 1'b0;
        tick(); en = 1'b1;
        tick();
        tick(); en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("drop_pair", {d0, d1}, 0);
        chk("drop_busy", busy, 0);
        chk("drop_ur", underrun, 0);
        chk("drop_fill", fill, 1);
        tick(); en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resume_ws", word_start, 1);
        chk("resume_pair", {d0, d1}, 2);

        // Randomized traffic with enable toggles and occasional reset
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst     = ($urandom % 150 == 0);
            if ($urandom % 16 == 0) en = ~en;
            s_valid = ($urandom % 4 != 0);
            s_data  = WIDTH'($urandom);
        end
        tick();
        rst = 1'b0; s_valid = 1'b0; en = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        chk("drain_fill", fill, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
